window_scheduler: RTL and testbench

//  Frame-level scheduler between the window sweeper and a pool of NUM_ENG cascade engines.
//  - Takes window positions (scale/y/x) from the sweeper stream.
//  - Dispatches each window to a free engine, round-robin, and remembers which window each engine holds.
//  - Collects pass/fail results and emits the position of every passing window as a detection.
//  - Runs one frame per start pulse and pulses done when the frame has fully drained.

---
 rtl/window_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_window_scheduler.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_scheduler.sv
// window_scheduler: hands sweeper windows to a pool of cascade engines round-robin,
// remembers each engine's window position and turns passing results into detections.
//
// state   | meaning
// S_IDLE  | waiting for a frame start pulse
// S_RUN   | accepting windows from the sweeper and dispatching them
// S_DRAIN | end of frame seen; waiting for engines and the detection slot to empty
module window_scheduler #(
  parameter int NUM_ENG = 4,
  parameter int W_X     = 9,
  parameter int W_Y     = 8,
  parameter int W_SCALE = 8,
  parameter int W_CNT   = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  input  logic               i_win_valid,
  output logic               o_win_ready,
  input  logic               i_win_eot,
  input  logic [W_SCALE-1:0] i_win_scale,
  input  logic [W_Y-1:0]     i_win_y,
  input  logic [W_X-1:0]     i_win_x,
  output logic [NUM_ENG-1:0] o_eng_start,
  output logic [W_SCALE-1:0] o_eng_scale,
  output logic [W_Y-1:0]     o_eng_y,
  output logic [W_X-1:0]     o_eng_x,
  input  logic [NUM_ENG-1:0] i_res_valid,
  input  logic [NUM_ENG-1:0] i_res_pass,
  output logic [NUM_ENG-1:0] o_res_ready,
  output logic               o_det_valid,
  input  logic               i_det_ready,
  output logic [W_SCALE-1:0] o_det_scale,
  output logic [W_Y-1:0]     o_det_y,
  output logic [W_X-1:0]     o_det_x,
  output logic [W_CNT-1:0]   o_win_cnt,
  output logic [W_CNT-1:0]   o_det_cnt
);

  localparam int W_PTR = $clog2(NUM_ENG);
  localparam int W_POS = W_SCALE + W_Y + W_X;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t             r_state;
  logic [NUM_ENG-1:0] r_busy;
  logic [W_PTR-1:0]   r_dp;
  logic [W_PTR-1:0]   r_rp;
  logic [W_POS-1:0]   r_tag [NUM_ENG];
  logic [NUM_ENG-1:0] r_eng_start;
  logic [W_POS-1:0]   r_eng_pos;
  logic               r_det_valid;
  logic [W_POS-1:0]   r_det_pos;
  logic [W_CNT-1:0]   r_win_cnt;
  logic [W_CNT-1:0]   r_det_cnt;
  logic               r_done;

  logic [W_PTR-1:0]   w_dk;
  logic [W_PTR-1:0]   w_gk;
  logic [W_PTR-1:0]   w_disp_idx;
  logic [W_PTR-1:0]   w_gnt_idx;
  logic               w_disp_found;
  logic               w_gnt_found;
  logic               w_slot_free;
  logic               w_ack;
  logic               w_win_hs;
  logic               w_disp;
  logic               w_eot_hs;
  logic [W_PTR-1:0]   w_dp_next;
  logic [W_PTR-1:0]   w_rp_next;
  logic [NUM_ENG-1:0] w_set;
  logic [W_POS-1:0]   w_win_pos;

  // first free engine at or after the dispatch pointer
  always_comb begin
    w_disp_found = 1'b0;
    w_disp_idx   = '0;
    w_dk         = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      w_dk = W_PTR'((int'(r_dp) + i) % NUM_ENG);
      if (!w_disp_found && !r_busy[w_dk]) begin
        w_disp_found = 1'b1;
        w_disp_idx   = w_dk;
      end
    end
  end

  // round-robin grant among busy engines reporting a result
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_gk        = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      w_gk = W_PTR'((int'(r_rp) + i) % NUM_ENG);
      if (!w_gnt_found && r_busy[w_gk] && i_res_valid[w_gk]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_gk;
      end
    end
  end

  // a failing result never needs the detection slot, so it is acked regardless
  assign w_slot_free = !r_det_valid || i_det_ready;
  assign w_ack       = w_gnt_found && (!i_res_pass[w_gnt_idx] || w_slot_free);
  assign o_res_ready = w_ack ? (NUM_ENG'(1) << w_gnt_idx) : '0;

  assign o_win_ready = (r_state == S_RUN) && (i_win_eot || w_disp_found);
  assign w_win_hs    = i_win_valid && o_win_ready;
  assign w_disp      = w_win_hs && !i_win_eot;
  assign w_eot_hs    = w_win_hs && i_win_eot;
  assign w_dp_next   = W_PTR'((int'(w_disp_idx) + 1) % NUM_ENG);
  assign w_rp_next   = W_PTR'((int'(w_gnt_idx) + 1) % NUM_ENG);
  assign w_set       = w_disp ? (NUM_ENG'(1) << w_disp_idx) : '0;
  assign w_win_pos   = {i_win_scale, i_win_y, i_win_x};

  // frame FSM, engine occupancy, dispatch and detection registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= '0;
      r_dp        <= '0;
      r_rp        <= '0;
      r_eng_start <= '0;
      r_eng_pos   <= '0;
      r_det_valid <= 1'b0;
      r_det_pos   <= '0;
      r_win_cnt   <= '0;
      r_det_cnt   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_eng_start <= '0;
      r_done      <= 1'b0;
      // set and clear masks never overlap: dispatch picks a free engine, ack a busy one
      r_busy      <= (r_busy | w_set) & ~o_res_ready;
      if (w_disp) begin
        r_eng_start <= w_set;
        r_eng_pos   <= w_win_pos;
        r_dp        <= w_dp_next;
        if (r_win_cnt != '1) r_win_cnt <= r_win_cnt + W_CNT'(1);
      end
      if (w_ack) begin
        r_rp <= w_rp_next;
        if (i_res_pass[w_gnt_idx]) begin
          r_det_valid <= 1'b1;
          r_det_pos   <= r_tag[w_gnt_idx];
          if (r_det_cnt != '1) r_det_cnt <= r_det_cnt + W_CNT'(1);
        end else if (i_det_ready) begin
          r_det_valid <= 1'b0;
        end
      end else if (i_det_ready) begin
        r_det_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state   <= S_RUN;
          r_win_cnt <= '0;
          r_det_cnt <= '0;
        end
        S_RUN: if (w_eot_hs) r_state <= S_DRAIN;
        S_DRAIN: if (r_busy == '0 && !r_det_valid) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // window position held per engine until its result is acked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENG; i++) r_tag[i] <= '0;
    end else if (w_disp) begin
      r_tag[w_disp_idx] <= w_win_pos;
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;
  assign o_eng_start = r_eng_start;
  assign o_eng_scale = r_eng_pos[W_POS-1 -: W_SCALE];
  assign o_eng_y     = r_eng_pos[W_X +: W_Y];
  assign o_eng_x     = r_eng_pos[W_X-1:0];
  assign o_det_valid = r_det_valid;
  assign o_det_scale = r_det_pos[W_POS-1 -: W_SCALE];
  assign o_det_y     = r_det_pos[W_X +: W_Y];
  assign o_det_x     = r_det_pos[W_X-1:0];
  assign o_win_cnt   = r_win_cnt;
  assign o_det_cnt   = r_det_cnt;

endmodule

// File: tb/tb_window_scheduler.sv
// tb_window_scheduler: directed scenarios plus a randomized lockstep reference model.
module tb_window_scheduler;
  localparam int N  = 4;
  localparam int WX = 9;
  localparam int WY = 8;
  localparam int WS = 8;
  localparam int WC = 4;
  localparam int WP = WS + WY + WX;
  localparam int CMAX = (1 << WC) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start, busy, done;
  logic          win_valid, win_ready, win_eot;
  logic [WS-1:0] win_scale;
  logic [WY-1:0] win_y;
  logic [WX-1:0] win_x;
  logic [N-1:0]  eng_start;
  logic [WS-1:0] eng_scale;
  logic [WY-1:0] eng_y;
  logic [WX-1:0] eng_x;
  logic [N-1:0]  res_valid, res_pass, res_ready;
  logic          det_valid, det_ready;
  logic [WS-1:0] det_scale;
  logic [WY-1:0] det_y;
  logic [WX-1:0] det_x;
  logic [WC-1:0] win_cnt, det_cnt;

  int checks = 0;
  int errors = 0;

  window_scheduler #(.NUM_ENG(N), .W_X(WX), .W_Y(WY), .W_SCALE(WS), .W_CNT(WC)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
    .i_win_valid(win_valid), .o_win_ready(win_ready), .i_win_eot(win_eot),
    .i_win_scale(win_scale), .i_win_y(win_y), .i_win_x(win_x),
    .o_eng_start(eng_start), .o_eng_scale(eng_scale), .o_eng_y(eng_y), .o_eng_x(eng_x),
    .i_res_valid(res_valid), .i_res_pass(res_pass), .o_res_ready(res_ready),
    .o_det_valid(det_valid), .i_det_ready(det_ready),
    .o_det_scale(det_scale), .o_det_y(det_y), .o_det_x(det_x),
    .o_win_cnt(win_cnt), .o_det_cnt(det_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    start = 0; win_valid = 0; win_eot = 0; win_scale = '0; win_y = '0; win_x = '0;
    res_valid = '0; res_pass = '0; det_ready = 0;
  endtask

  task automatic set_win(input int k);
    win_scale = WS'(k + 1);
    win_y     = WY'(3 * k + 2);
    win_x     = WX'(5 * k + 7);
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();
  endtask

  task automatic begin_frame();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic dispatch_n(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      set_win(base + i);
      win_valid = 1;
      tick();
    end
    win_valid = 0;
  endtask

  task automatic test_reset();
    idle_in();
    win_valid = 1; win_eot = 1; res_valid = '1; res_pass = '1; start = 1;
    rst_n = 0;
    #2;
    checks++;
    if ({busy, done, win_ready, eng_start, res_ready, det_valid, win_cnt, det_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {busy, done, win_ready, eng_start, res_ready, det_valid, win_cnt, det_cnt});
    end
    repeat (2) @(posedge clk);
    idle_in();
    #1 rst_n = 1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [N-1:0] ord [3];
    logic [N-1:0] rr;
    int n_ack, done_cnt;
    bit seen_det;
    ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b0100;
    n_ack = 0; done_cnt = 0; seen_det = 0;
    do_reset();
    begin_frame();
    for (int i = 0; i < 3; i++) begin
      set_win(i);
      win_valid = 1;
      #1;
      checks++;
      if (win_ready !== 1'b1) begin errors++; $display("FAIL basic_ready[%0d] got %b want 1", i, win_ready); end
      tick();
      checks++;
      if (eng_start !== (N'(1) << i) || eng_x !== WX'(5 * i + 7)) begin
        errors++;
        $display("FAIL basic_start[%0d] got %b/%0d want %b/%0d", i, eng_start, eng_x, N'(1) << i, 5 * i + 7);
      end
    end
    win_eot = 1;
    tick();
    win_valid = 0; win_eot = 0;
    checks++;
    if (eng_start !== '0 || busy !== 1'b1 || win_cnt !== WC'(3)) begin
      errors++;
      $display("FAIL basic_eot got start=%b busy=%b win_cnt=%0d want 0/1/3", eng_start, busy, win_cnt);
    end
    res_valid = 4'b0111; res_pass = '0; det_ready = 1;
    for (int c = 0; c < 30; c++) begin
      #1;
      rr = res_ready;
      if (rr != '0) begin
        checks++;
        if (n_ack > 2 || rr !== ord[n_ack > 2 ? 2 : n_ack]) begin
          errors++;
          $display("FAIL basic_ack_order[%0d] got %b", n_ack, rr);
        end
        n_ack++;
      end
      if (det_valid) seen_det = 1;
      if (done) done_cnt++;
      @(posedge clk);
      #1 res_valid = res_valid & ~rr;
    end
    checks++;
    if (n_ack != 3 || done_cnt != 1 || seen_det || win_cnt !== WC'(3) || det_cnt !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_end got acks=%0d done=%0d det=%0b win_cnt=%0d det_cnt=%0d busy=%b want 3/1/0/3/0/0",
               n_ack, done_cnt, seen_det, win_cnt, det_cnt, busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    begin_frame();
    for (int i = 0; i < 4; i++) begin
      set_win(10 + i);
      win_valid = 1;
      tick();
      checks++;
      if (eng_start !== (N'(1) << i)) begin errors++; $display("FAIL bp_start[%0d] got %b want %b", i, eng_start, N'(1) << i); end
    end
    set_win(20);
    #1;
    checks++;
    if (win_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", win_ready); end
    tick();
    res_valid = 4'b0100; res_pass = '0;
    #1;
    checks++;
    if (res_ready !== 4'b0100 || win_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ack got res_ready=%b win_ready=%b want 0100/0", res_ready, win_ready);
    end
    tick();
    res_valid = '0;
    #1;
    checks++;
    if (win_ready !== 1'b1) begin errors++; $display("FAIL bp_refill_ready got %b want 1", win_ready); end
    tick();
    win_valid = 0;
    checks++;
    if (eng_start !== 4'b0100 || eng_x !== WX'(107) || win_cnt !== WC'(5)) begin
      errors++;
      $display("FAIL bp_refill got start=%b x=%0d win_cnt=%0d want 0100/107/5", eng_start, eng_x, win_cnt);
    end
  endtask

  task automatic test_det_order();
    do_reset();
    begin_frame();
    dispatch_n(30, 4);
    det_ready = 0; res_valid = 4'b1001; res_pass = 4'b1001;
    #1;
    checks++;
    if (res_ready !== 4'b0001) begin errors++; $display("FAIL det_first_ack got %b want 0001", res_ready); end
    tick();
    res_valid = 4'b1000;
    #1;
    checks++;
    if (det_valid !== 1'b1 || det_x !== WX'(157) || det_y !== WY'(92) || det_scale !== WS'(31) || res_ready !== '0) begin
      errors++;
      $display("FAIL det_first got v=%b pos=%0d/%0d/%0d rr=%b want 1 31/92/157 0000", det_valid, det_scale, det_y, det_x, res_ready);
    end
    tick();
    tick();
    checks++;
    if (det_valid !== 1'b1 || det_x !== WX'(157)) begin
      errors++;
      $display("FAIL det_hold got v=%b x=%0d want 1/157", det_valid, det_x);
    end
    det_ready = 1;
    #1;
    checks++;
    if (res_ready !== 4'b1000) begin errors++; $display("FAIL det_second_ack got %b want 1000", res_ready); end
    tick();
    res_valid = '0;
    checks++;
    if (det_valid !== 1'b1 || det_x !== WX'(172) || det_scale !== WS'(34)) begin
      errors++;
      $display("FAIL det_second got v=%b x=%0d s=%0d want 1/172/34", det_valid, det_x, det_scale);
    end
    tick();
    checks++;
    if (det_valid !== 1'b0 || det_cnt !== WC'(2)) begin
      errors++;
      $display("FAIL det_end got v=%b det_cnt=%0d want 0/2", det_valid, det_cnt);
    end
  endtask

  task automatic test_drain();
    logic [N-1:0] rr;
    int done_cnt;
    done_cnt = 0;
    do_reset();
    begin_frame();
    dispatch_n(40, 2);
    win_valid = 1; win_eot = 1;
    tick();
    #1;
    checks++;
    if (busy !== 1'b1 || win_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_state got busy=%b win_ready=%b want 1/0", busy, win_ready);
    end
    win_valid = 0; win_eot = 0;
    det_ready = 0; res_valid = 4'b0011; res_pass = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      #1 rr = res_ready;
      if (done) done_cnt++;
      @(posedge clk);
      #1 res_valid = res_valid & ~rr;
    end
    checks++;
    if (res_valid !== '0 || det_valid !== 1'b1 || done_cnt != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drain_wait got rv=%b det=%b done=%0d busy=%b want 0000/1/0/1", res_valid, det_valid, done_cnt, busy);
    end
    det_ready = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done) done_cnt++;
    end
    checks++;
    if (done_cnt != 1 || det_valid !== 1'b0 || busy !== 1'b0 || det_cnt !== WC'(1)) begin
      errors++;
      $display("FAIL drain_done got done=%0d det=%b busy=%b det_cnt=%0d want 1/0/0/1", done_cnt, det_valid, busy, det_cnt);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    begin_frame();
    dispatch_n(50, 4);
    det_ready = 0; res_valid = 4'b0001; res_pass = 4'b0001;
    tick();
    res_valid = '0;
    #2;
    win_valid = 1; res_valid = '1;
    rst_n = 0;
    #1;
    checks++;
    if ({busy, done, win_ready, eng_start, res_ready, det_valid, win_cnt, det_cnt} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want 0", {busy, done, win_ready, eng_start, res_ready, det_valid, win_cnt, det_cnt});
    end
    idle_in();
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    begin_frame();
    dispatch_n(60, 1);
    checks++;
    if (eng_start !== 4'b0001) begin errors++; $display("FAIL midreset_dp got %b want 0001", eng_start); end
    dispatch_n(61, 1);
    res_valid = 4'b0011; res_pass = '0;
    #1;
    checks++;
    if (res_ready !== 4'b0001) begin errors++; $display("FAIL midreset_rp got %b want 0001", res_ready); end
    res_valid = '0;
  endtask

  task automatic test_saturate();
    int n;
    bit hs, done_seen;
    n = 0; done_seen = 0;
    do_reset();
    begin_frame();
    res_valid = '1; res_pass = '1; det_ready = 1;
    for (int c = 0; c < 200 && n < 18; c++) begin
      set_win(n);
      win_valid = 1;
      #1 hs = win_ready;
      tick();
      if (hs) n++;
    end
    win_eot = 1;
    for (int c = 0; c < 20 && win_valid; c++) begin
      #1 hs = win_ready;
      tick();
      if (hs) win_valid = 0;
    end
    win_eot = 0; win_valid = 0;
    for (int c = 0; c < 50 && !done_seen; c++) begin
      tick();
      if (done) done_seen = 1;
    end
    checks++;
    if (n != 18 || !done_seen || win_cnt !== WC'(CMAX) || det_cnt !== WC'(CMAX)) begin
      errors++;
      $display("FAIL saturate got sent=%0d done=%0b win_cnt=%0d det_cnt=%0d want 18/1/%0d/%0d", n, done_seen, win_cnt, det_cnt, CMAX, CMAX);
    end
    idle_in();
  endtask

  task automatic test_random();
    int st, dp, rp, wcnt, dcnt, dk, g, k, n_win, sent, cyc;
    bit mb [N];
    logic [WP-1:0] mt [N];
    int lat [N];
    bit ep [N];
    bit mdv, ack, hs, all_free, started, exp_done, exp_wr;
    logic [WP-1:0] mdp, exp_ep;
    logic [N-1:0] exp_es, exp_rr;
    do_reset();
    st = 0; dp = 0; rp = 0; wcnt = 0; dcnt = 0; mdv = 0; mdp = '0; exp_ep = '0;
    for (int i = 0; i < N; i++) begin mb[i] = 0; mt[i] = '0; lat[i] = 0; ep[i] = 0; end
    for (int f = 0; f < 3; f++) begin
      n_win = $urandom_range(4, 20); sent = 0; cyc = 0; started = 0;
      while (cyc < 600 && !(started && st == 0)) begin
        cyc++;
        for (int i = 0; i < N; i++) if (mb[i] && lat[i] > 0) lat[i]--;
        start     = (st == 0) ? 1'b1 : ($urandom_range(0, 9) == 0);
        win_valid = (st == 1) && ($urandom_range(0, 3) != 0);
        win_eot   = (sent >= n_win);
        {win_scale, win_y, win_x} = WP'($urandom);
        det_ready = ($urandom_range(0, 2) != 0);
        for (int i = 0; i < N; i++) begin
          if (mb[i]) begin res_valid[i] = (lat[i] == 0); res_pass[i] = ep[i]; end
          else begin res_valid[i] = ($urandom_range(0, 7) == 0); res_pass[i] = 1'($urandom_range(0, 1)); end
        end
        #1;
        dk = -1; g = -1; all_free = 1;
        for (int o = 0; o < N; o++) begin
          k = (dp + o) % N;
          if (dk < 0 && !mb[k]) dk = k;
          k = (rp + o) % N;
          if (g < 0 && mb[k] && res_valid[k]) g = k;
          if (mb[o]) all_free = 0;
        end
        exp_wr = (st == 1) && (win_eot || dk >= 0);
        ack    = (g >= 0) && (!res_pass[g] || !mdv || det_ready);
        exp_rr = ack ? (N'(1) << g) : '0;
        checks++;
        if (win_ready !== exp_wr || res_ready !== exp_rr) begin
          errors++;
          $display("FAIL rnd_comb f%0d c%0d got wr=%b rr=%b want %b/%b", f, cyc, win_ready, res_ready, exp_wr, exp_rr);
        end
        hs = win_valid && exp_wr;
        exp_es = '0; exp_done = 0;
        if (st == 0) begin
          if (start) begin st = 1; wcnt = 0; dcnt = 0; started = 1; end
        end else begin
          if (st == 2 && all_free && !mdv) begin st = 0; exp_done = 1; end
          if (hs && !win_eot) begin
            mb[dk] = 1; mt[dk] = {win_scale, win_y, win_x};
            exp_es = N'(1) << dk; exp_ep = mt[dk];
            dp = (dk + 1) % N;
            if (wcnt < CMAX) wcnt++;
            lat[dk] = $urandom_range(0, 5); ep[dk] = 1'($urandom_range(0, 1));
            sent++;
          end
          if (hs && win_eot) st = 2;
          if (ack) begin
            mb[g] = 0; rp = (g + 1) % N;
            if (res_pass[g]) begin mdv = 1; mdp = mt[g]; if (dcnt < CMAX) dcnt++; end
            else if (det_ready) mdv = 0;
          end else if (det_ready) mdv = 0;
        end
        tick();
        checks++;
        if (busy !== (st != 0) || done !== exp_done || eng_start !== exp_es || det_valid !== mdv ||
            win_cnt !== WC'(wcnt) || det_cnt !== WC'(dcnt)) begin
          errors++;
          $display("FAIL rnd_regs f%0d c%0d got busy=%b done=%b es=%b dv=%b wc=%0d dc=%0d want %b/%b/%b/%b/%0d/%0d",
                   f, cyc, busy, done, eng_start, det_valid, win_cnt, det_cnt, st != 0, exp_done, exp_es, mdv, wcnt, dcnt);
        end
        if (exp_es != '0) begin
          checks++;
          if ({eng_scale, eng_y, eng_x} !== exp_ep) begin
            errors++;
            $display("FAIL rnd_eng_pos f%0d c%0d got %h want %h", f, cyc, {eng_scale, eng_y, eng_x}, exp_ep);
          end
        end
        if (mdv) begin
          checks++;
          if ({det_scale, det_y, det_x} !== mdp) begin
            errors++;
            $display("FAIL rnd_det_pos f%0d c%0d got %h want %h", f, cyc, {det_scale, det_y, det_x}, mdp);
          end
        end
      end
      checks++;
      if (!(started && st == 0)) begin errors++; $display("FAIL rnd_timeout frame %0d state %0d want 0", f, st); end
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_basic();
    test_backpressure();
    test_det_order();
    test_drain();
    test_reset_midframe();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
